// File: rtl/axis_fifo_burst_reader_pkg.sv
// Shared types and default sizes for the AXI-Stream FIFO burst reader.
// Contents: controller state enum, default stream/count widths, default flush timeout.
package axis_fifo_burst_reader_pkg;

  localparam int unsigned DefTdataWidth    = 32;
  localparam int unsigned DefCntWidth      = 16;
  localparam int unsigned DefTimeoutCycles = 1024;

  typedef enum logic {
    StIdle,
    StBurst
  } state_e;

endpackage

// File: rtl/axis_burst_timeout.sv
// Idle-flush timer for axis_fifo_burst_reader (present only when
// AXIS_FIFO_BURST_READER_TIMEOUT_EN is defined).
// Ports:
//   i_clk     clock
//   i_rst_n   asynchronous active-low reset
//   i_inc     count this cycle (partial data waiting while idle)
//   i_clr     clear the timer
//   o_expire  timer has reached TIMEOUT_CYCLES-1 while counting
`ifdef AXIS_FIFO_BURST_READER_TIMEOUT_EN
module axis_burst_timeout
  import axis_fifo_burst_reader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_expire
);

  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT_CYCLES - 1);

  logic [TimerW-1:0] r_timer;

  assign o_expire = i_inc && (r_timer == TimerMax);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_timer <= '0;
    end else if (i_clr || o_expire) begin
      r_timer <= '0;
    end else if (i_inc) begin
      r_timer <= r_timer + TimerW'(1);
    end
  end

endmodule
`endif

// File: rtl/axis_fifo_burst_reader.sv
// Drain-side controller for a synchronous AXI-Stream FIFO. Waits until a full burst of
// cfg_data words is buffered, then passes exactly that many words downstream with tlast
// on the final one. Optional macro AXIS_FIFO_BURST_READER_TIMEOUT_EN adds an idle timer
// that flushes a partial burst after TIMEOUT_CYCLES cycles.
// Ports:
//   aclk, aresetn          clock, asynchronous active-low reset
//   cfg_data               burst length L (0 disables)
//   fifo_count             words readable in the upstream FIFO
//   s_axis_*               FIFO master port (tdata/tvalid in, tready out)
//   m_axis_*               downstream stream (tdata/tvalid/tlast out, tready in)
//   busy                   burst in progress
//   sts_bursts             completed-burst counter (wraps)
module axis_fifo_burst_reader
  import axis_fifo_burst_reader_pkg::*;
#(
  parameter int unsigned AXIS_TDATA_WIDTH = DefTdataWidth,
  parameter int unsigned CNT_WIDTH        = DefCntWidth,
  parameter int unsigned TIMEOUT_CYCLES   = DefTimeoutCycles
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [CNT_WIDTH-1:0]        cfg_data,
  input  logic [CNT_WIDTH-1:0]        fifo_count,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  output logic                        busy,
  output logic [31:0]                 sts_bursts
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_e               r_state;
  logic                 r_busy;
  logic [31:0]          r_sts_bursts;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] r_len;

  logic w_in_burst;
  logic w_xfer;
  logic w_last;
  logic w_start_full;
  logic w_start_short;

  assign w_in_burst   = (r_state == StBurst);
  assign w_xfer       = w_in_burst && s_axis_tvalid && m_axis_tready;
  // r_len is never 0 in BURST, so len-1 does not underflow there.
  assign w_last       = w_in_burst && (r_cnt == r_len - CNT_WIDTH'(1));
  assign w_start_full = (cfg_data != '0) && (fifo_count >= cfg_data);

`ifdef AXIS_FIFO_BURST_READER_TIMEOUT_EN
  logic w_tmo_inc;
  logic w_tmo_expire;

  // Count only while idle with some, but not a full burst of, data waiting.
  assign w_tmo_inc = !w_in_burst && (fifo_count != '0) && (fifo_count < cfg_data);

  axis_burst_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk   (aclk),
    .i_rst_n (aresetn),
    .i_inc   (w_tmo_inc),
    .i_clr   (!w_tmo_inc),
    .o_expire(w_tmo_expire)
  );

  assign w_start_short = w_tmo_expire;
`else
  assign w_start_short = 1'b0;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state      <= StIdle;
      r_busy       <= 1'b0;
      r_sts_bursts <= '0;
      r_cnt        <= '0;
      r_len        <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_start_full) begin
            r_state <= StBurst;
            r_len   <= cfg_data;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end else if (w_start_short) begin
            r_state <= StBurst;
            r_len   <= fifo_count;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        StBurst: begin
          if (w_xfer) begin
            if (w_last) begin
              r_state      <= StIdle;
              r_busy       <= 1'b0;
              r_sts_bursts <= r_sts_bursts + 32'd1;
              r_cnt        <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_WIDTH'(1);
            end
          end
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tvalid = w_in_burst && s_axis_tvalid;
  assign s_axis_tready = w_in_burst && m_axis_tready;
  assign m_axis_tlast  = w_last;
  assign busy          = r_busy;
  assign sts_bursts    = r_sts_bursts;

endmodule

// File: tb/tb_axis_fifo_burst_reader.sv
module tb_axis_fifo_burst_reader;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [15:0] cfg_data;
  logic [15:0] fifo_count;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        busy;
  logic [31:0] sts_bursts;

  int n_cmp = 0;
  int n_err = 0;

  always #5 aclk = ~aclk;

  axis_fifo_burst_reader #(
    .AXIS_TDATA_WIDTH(32),
    .CNT_WIDTH       (16),
    .TIMEOUT_CYCLES  (16)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .cfg_data     (cfg_data),
    .fifo_count   (fifo_count),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .busy         (busy),
    .sts_bursts   (sts_bursts)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; sampling happens 1 time unit later.
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int xf;
    int w;
    logic vpat [9];

    // Reset
    aresetn       = 1'b0;
    cfg_data      = '0;
    fifo_count    = '0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tready", s_axis_tready, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_sts", sts_bursts, 0);
    tick_n(2);
    aresetn = 1'b1;
    tick();

    // Test 1: L=4, count 3 holds off, count 4 starts
    cfg_data      = 16'd4;
    fifo_count    = 16'd3;
    s_axis_tvalid = 1'b1;
    m_axis_tready = 1'b1;
    tick_n(3);
    check("t1_wait_busy", busy, 0);
    check("t1_wait_tvalid", m_axis_tvalid, 0);
    check("t1_wait_tready", s_axis_tready, 0);
    fifo_count = 16'd4;
    #1;
    check("t1_start_lat", busy, 0);
    tick();
    check("t1_busy", busy, 1);
    for (int k = 1; k <= 4; k++) begin
      s_axis_tdata = 32'hA000 + 32'(k);
      if (k == 4) fifo_count = 16'd0;
      #1;
      check("t1_tvalid", m_axis_tvalid, 1);
      check("t1_tready", s_axis_tready, 1);
      check("t1_tdata", m_axis_tdata, 32'hA000 + 32'(k));
      check("t1_tlast", m_axis_tlast, (k == 4) ? 32'd1 : 32'd0);
      tick();
    end
    check("t1_end_busy", busy, 0);
    check("t1_end_tvalid", m_axis_tvalid, 0);
    check("t1_sts", sts_bursts, 1);

    // Test 2: L=8, downstream ready toggling, FIFO full
    cfg_data      = 16'd8;
    fifo_count    = 16'd100;
    m_axis_tready = 1'b0;
    tick();
    check("t2_busy", busy, 1);
    xf = 0;
    for (int c = 0; c < 15; c++) begin
      m_axis_tready = (c % 2 == 0);
      #1;
      check("t2_tready", s_axis_tready, (c % 2 == 0) ? 32'd1 : 32'd0);
      if (m_axis_tvalid && m_axis_tready) begin
        xf++;
        check("t2_tlast", m_axis_tlast, (xf == 8) ? 32'd1 : 32'd0);
      end
      tick();
    end
    check("t2_xfers", 32'(xf), 8);
    check("t2_bubble_busy", busy, 0);
    check("t2_bubble_tvalid", m_axis_tvalid, 0);
    check("t2_sts", sts_bursts, 2);

    // Test 3: L=6 with underflow after word 2; cfg changed to 2 during word 3
    cfg_data      = 16'd6;
    m_axis_tready = 1'b1;
    tick();
    check("t3_busy", busy, 1);
    vpat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    w = 0;
    for (int c = 0; c < 9; c++) begin
      s_axis_tvalid = vpat[c];
      if (c == 5) cfg_data = 16'd2;
      if (c == 8) fifo_count = 16'd0;
      #1;
      check("t3_tvalid", m_axis_tvalid, 32'(vpat[c]));
      if (vpat[c]) begin
        w++;
        check("t3_tlast", m_axis_tlast, (w == 6) ? 32'd1 : 32'd0);
      end else begin
        check("t3_hold_tlast", m_axis_tlast, 0);
      end
      tick();
    end
    check("t3_end_busy", busy, 0);
    check("t3_sts", sts_bursts, 3);

    // Test 4: next burst uses L=2
    fifo_count = 16'd1;
    tick_n(2);
    check("t4_wait_busy", busy, 0);
    fifo_count = 16'd2;
    tick();
    check("t4_busy", busy, 1);
    #1;
    check("t4_w1_tlast", m_axis_tlast, 0);
    tick();
    fifo_count = 16'd0;
    #1;
    check("t4_w2_tlast", m_axis_tlast, 1);
    tick();
    check("t4_end_busy", busy, 0);
    check("t4_sts", sts_bursts, 4);

    // Test 5: reset asserted at word 3 of a 10-word burst
    cfg_data   = 16'd10;
    fifo_count = 16'd100;
    tick();
    check("t5_busy", busy, 1);
    tick_n(2);
    check("t5_w3_tvalid", m_axis_tvalid, 1);
    aresetn = 1'b0;
    #1;
    check("t5_rst_tvalid", m_axis_tvalid, 0);
    check("t5_rst_tready", s_axis_tready, 0);
    check("t5_rst_tlast", m_axis_tlast, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_sts", sts_bursts, 0);
    fifo_count = 16'd0;
    tick();
    aresetn = 1'b1;
    tick();
    check("t5_post_busy", busy, 0);
    check("t5_post_tvalid", m_axis_tvalid, 0);
    check("t5_post_sts", sts_bursts, 0);

    // Test 6: L=0 disabled, then L=1 single-word burst
    cfg_data   = 16'd0;
    fifo_count = 16'd5;
    tick_n(3);
    check("t6_l0_busy", busy, 0);
    cfg_data   = 16'd1;
    fifo_count = 16'd1;
    tick();
    check("t6_l1_busy", busy, 1);
    fifo_count = 16'd0;
    #1;
    check("t6_l1_tlast", m_axis_tlast, 1);
    tick();
    check("t6_l1_end_busy", busy, 0);
    check("t6_l1_sts", sts_bursts, 1);

    // Test 7: partial data, L=8, fifo_count held at 3
    cfg_data   = 16'd8;
    fifo_count = 16'd3;
`ifdef AXIS_FIFO_BURST_READER_TIMEOUT_EN
    tick_n(15);
    check("t7_pre_busy", busy, 0);
    tick();
    check("t7_busy", busy, 1);
    for (int k = 1; k <= 3; k++) begin
      if (k == 3) fifo_count = 16'd0;
      #1;
      check("t7_tlast", m_axis_tlast, (k == 3) ? 32'd1 : 32'd0);
      tick();
    end
    check("t7_end_busy", busy, 0);
    check("t7_sts", sts_bursts, 2);
`else
    for (int c = 0; c < 40; c++) begin
      tick();
      check("t7_no_burst", busy, 0);
    end
    check("t7_sts", sts_bursts, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
